pixel_plotter: RTL and testbench

PIXEL_PLOTTER -- requirements
Module: pixel_plotter

---
 rtl/pixel_plotter.sv | 193 +++++++++++++++++++
 tb/tb_pixel_plotter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plotter.sv
// pixel_plotter: queues (x,y,color) plot requests and turns them into framebuffer writes; clear_req sweeps the buffer with CLEAR_COLOR.
// Latency: a request accepted on edge N shows fb_we=1 after edge N+1 when idle with an empty queue.
// Backpressure: in_ready drops while the FIFO_DEPTH-entry queue is full; requests keep queueing during a clear.
//
// Ports: clk, rst (async, active-high)
//        in_valid/in_ready/in_x/in_y/in_color : plot request handshake
//        clear_req : one-cycle pulse starting a full-screen clear
//        busy      : clear running or requests still queued
//        fb_we/fb_addr/fb_data : registered framebuffer write port
//        drop_count: saturating count of discarded off-screen requests
// Build option: define PIXEL_PLOTTER_CLIP_EN to discard requests outside FB_W x FB_H
// instead of writing them at their wrapped address (drop_count is then live, otherwise 0).

// Small generic FIFO: push ignored when full, pop ignored when empty, head visible on dat_o.
module pixel_plotter_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] dat_i,
  input  logic         pop_i,
  output logic [W-1:0] dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dat_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= dat_i;
  end
endmodule

module pixel_plotter #(
  parameter int         FB_W        = 160,
  parameter int         FB_H        = 120,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  input  logic [2:0]  in_color,
  input  logic        clear_req,
  output logic        busy,
  output logic        fb_we,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic [7:0]  drop_count
);
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] color;
  } req_t;

  typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

  localparam logic [14:0] LAST_ADDR = 15'(FB_W * FB_H - 1);

  state_t      state_q, state_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic        fb_we_q, fb_we_d;
  logic [14:0] fb_addr_q, fb_addr_d;
  logic [2:0]  fb_data_q, fb_data_d;

  req_t        push_dat, head;
  logic        fifo_full, fifo_empty;
  logic        pop;
  logic        clip;
  logic [14:0] head_addr;

  assign push_dat = {in_x, in_y, in_color};
  assign in_ready = !fifo_full;

  pixel_plotter_fifo #(
    .W     ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .dat_i   (push_dat),
    .pop_i   (pop),
    .dat_o   (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // 15-bit arithmetic: off-screen coordinates wrap modulo 2^15.
  assign head_addr = 15'(head.y) * 15'(FB_W) + 15'(head.x);

`ifdef PIXEL_PLOTTER_CLIP_EN
  logic [7:0] drop_q, drop_d;

  assign clip = ({24'd0, head.x} >= 32'(FB_W)) || ({24'd0, head.y} >= 32'(FB_H));

  always_comb begin
    drop_d = drop_q;
    if (pop && clip && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= 8'd0;
    else     drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign clip       = 1'b0;
  assign drop_count = 8'd0;
`endif

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    pop        = 1'b0;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    case (state_q)
      ST_IDLE: begin
        // A clear wins over a pending pop; queued entries wait until it ends.
        if (clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (!clip) begin
            fb_we_d   = 1'b1;
            fb_addr_d = head_addr;
            fb_data_d = head.color;
          end
        end
      end
      ST_CLEAR: begin
        fb_we_d   = 1'b1;
        fb_addr_d = clr_addr_q;
        fb_data_d = CLEAR_COLOR;
        if (clr_addr_q == LAST_ADDR) state_d = ST_IDLE;
        else                         clr_addr_d = clr_addr_q + 15'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
    end
  end

  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;
  assign busy    = (state_q == ST_CLEAR) || !fifo_empty;
endmodule

// File: tb/tb_pixel_plotter.sv
`timescale 1ns/1ps
module tb_pixel_plotter;
  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;
  localparam logic [2:0] CLR = 3'b000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic [2:0]  in_color;
  logic        clear_req;
  logic        busy;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;

  logic [17:0] obs_q[$];   // observed writes {addr, data}
  logic [17:0] exp_q[$];   // model writes

  always #5 clk = ~clk;

  pixel_plotter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_color(in_color), .clear_req(clear_req),
    .busy(busy), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .drop_count(drop_count)
  );

  always @(negedge clk) if (!rst && fb_we) obs_q.push_back({fb_addr, fb_data});

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit model_drop(input int x, input int y);
`ifdef PIXEL_PLOTTER_CLIP_EN
    return (x >= W) || (y >= H);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [17:0] model_word(input int x, input int y, input int c);
    logic [14:0] a;
    a = 15'((y * W + x) % 32768);
    return {a, 3'(c)};
  endfunction

  function automatic int sat255(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Mismatches between observed writes starting at 'start' and a full clear sweep.
  function automatic int clear_errs(input int start);
    int n = 0;
    if (obs_q.size() < start + NPIX) return NPIX;
    for (int i = 0; i < NPIX; i++)
      if (obs_q[start + i] !== {15'(i), CLR}) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers (start/end at posedge+1) ----------------
  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; clear_req = 1'b0;
    in_x = '0; in_y = '0; in_color = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic push(input int x, input int y, input int c, input int budget, output bit ok);
    int n = 0;
    in_valid = 1'b1; in_x = 8'(x); in_y = 8'(y); in_color = 3'(c);
    @(negedge clk);
    while (!in_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; clear_req = 1'b0;
    in_x = '0; in_y = '0; in_color = '0;
    #2;
    total++; if (fb_we !== 1'b0)      begin bad++; $display("FAIL reset_we: got %b want 0", fb_we); end
    total++; if (fb_addr !== 15'd0)   begin bad++; $display("FAIL reset_addr: got %0d want 0", fb_addr); end
    total++; if (fb_data !== 3'd0)    begin bad++; $display("FAIL reset_data: got %0d want 0", fb_data); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    apply_reset();
    total++; if (in_ready !== 1'b1 || busy !== 1'b0)
      begin bad++; $display("FAIL post_reset_idle: ready=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_single();
    logic [17:0] w;
    apply_reset();
    w = model_word(5, 15, 3'b010);
    in_valid = 1'b1; in_x = 8'd5; in_y = 8'd15; in_color = 3'b010;
    @(posedge clk); #1 in_valid = 1'b0;          // accepted on this edge (N)
    @(negedge clk);
    total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL single_early_we: got %b want 0", fb_we); end
    total++; if (busy !== 1'b1)  begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge clk);                              // after edge N+1
    total++; if ({fb_we, fb_addr, fb_data} !== {1'b1, w})
      begin bad++; $display("FAIL single_write: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=%0d", fb_we, fb_addr, fb_data, w[17:3], w[2:0]); end
    @(negedge clk);
    total++; if ({fb_we, fb_addr, fb_data} !== {1'b0, w})
      begin bad++; $display("FAIL single_hold: got we=%b addr=%0d data=%0d want we=0 addr=%0d data=%0d", fb_we, fb_addr, fb_data, w[17:3], w[2:0]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int xs[5], ys[5], cs[5];
    bit ok;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      xs[i] = $urandom_range(0, W - 1); ys[i] = $urandom_range(0, H - 1); cs[i] = $urandom_range(0, 7);
    end
    pulse_clear();                               // queue output now stalled
    for (int i = 0; i < 4; i++) begin
      push(xs[i], ys[i], cs[i], 5, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_accept%0d: ready=0 want 1", i); end
    end
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: in_ready=%b want 0", in_ready); end
    @(posedge clk); #1;
    push(xs[4], ys[4], cs[4], NPIX + 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_fifth: not accepted within budget"); end
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_drain: busy still 1"); end
    total++; if (obs_q.size() !== NPIX + 5) begin bad++; $display("FAIL b2b_count: got %0d writes want %0d", obs_q.size(), NPIX + 5); end
    total++; if (clear_errs(0) !== 0) begin bad++; $display("FAIL b2b_clear_seq: got %0d bad words want 0", clear_errs(0)); end
    for (int i = 0; i < 5; i++) begin
      logic [17:0] got;
      got = (obs_q.size() > NPIX + i) ? obs_q[NPIX + i] : 18'h3ffff;
      total++; if (got !== model_word(xs[i], ys[i], cs[i]))
        begin bad++; $display("FAIL b2b_order%0d: got %h want %h", i, got, model_word(xs[i], ys[i], cs[i])); end
    end
  endtask

  task automatic test_clear();
    bit prev_busy = 1'b1;
    bit found = 1'b0;
    apply_reset();
    pulse_clear();
    for (int c = 0; c < NPIX + 20 && !found; c++) begin
      @(negedge clk);
      if (fb_we && fb_addr == 15'(NPIX - 1)) begin
        found = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy_fall: busy=%b want 0", busy); end
        total++; if (prev_busy !== 1'b1) begin bad++; $display("FAIL clear_busy_before: busy=%b want 1", prev_busy); end
      end
      prev_busy = busy;
    end
    total++; if (!found) begin bad++; $display("FAIL clear_last: last address never written"); end
    repeat (5) @(negedge clk);
    total++; if (obs_q.size() !== NPIX) begin bad++; $display("FAIL clear_count: got %0d want %0d", obs_q.size(), NPIX); end
    total++; if (clear_errs(0) !== 0) begin bad++; $display("FAIL clear_seq: got %0d bad words want 0", clear_errs(0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_queued();
    int xa, ya, ca, xb, yb, cb;
    bit ok;
    apply_reset();
    xa = $urandom_range(0, W - 1); ya = $urandom_range(0, H - 1); ca = $urandom_range(0, 7);
    xb = $urandom_range(0, W - 1); yb = $urandom_range(0, H - 1); cb = $urandom_range(0, 7);
    in_valid = 1'b1; in_x = 8'(xa); in_y = 8'(ya); in_color = 3'(ca);
    @(posedge clk);
    #1 in_x = 8'(xb); in_y = 8'(yb); in_color = 3'(cb); clear_req = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; clear_req = 1'b0;
    repeat (50) @(posedge clk);
    #1 pulse_clear();                            // must be ignored mid-clear
    wait_idle(NPIX + 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL cq_drain: busy still 1"); end
    total++; if (obs_q.size() !== NPIX + 2) begin bad++; $display("FAIL cq_count: got %0d want %0d", obs_q.size(), NPIX + 2); end
    total++; if (clear_errs(0) !== 0) begin bad++; $display("FAIL cq_clear_seq: got %0d bad words want 0", clear_errs(0)); end
    if (obs_q.size() >= NPIX + 2) begin
      total++; if (obs_q[NPIX] !== model_word(xa, ya, ca))
        begin bad++; $display("FAIL cq_first: got %h want %h", obs_q[NPIX], model_word(xa, ya, ca)); end
      total++; if (obs_q[NPIX + 1] !== model_word(xb, yb, cb))
        begin bad++; $display("FAIL cq_second: got %h want %h", obs_q[NPIX + 1], model_word(xb, yb, cb)); end
    end
  endtask

  task automatic test_reset_mid_clear();
    bit found = 1'b0;
    int n;
    apply_reset();
    pulse_clear();
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (fb_we && fb_addr == 15'd100) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL rmc_reach: address 100 never written"); end
    #1 rst = 1'b1;
    #1;
    total++; if (fb_we !== 1'b0)    begin bad++; $display("FAIL rmc_we: got %b want 0", fb_we); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rmc_busy: got %b want 0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmc_ready: got %b want 1", in_ready); end
    n = obs_q.size();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(negedge clk);
    total++; if (obs_q.size() !== n) begin bad++; $display("FAIL rmc_quiet: got %0d writes want %0d", obs_q.size(), n); end
    @(posedge clk); #1;
  endtask

  task automatic test_clip_edges();
    int drops = 0;
    bit ok;
    int ex[3] = '{W, W - 1, 0};
    int ey[3] = '{0, H - 1, H};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      int c;
      c = $urandom_range(0, 7);
      push(ex[i], ey[i], c, 10, ok);
      if (model_drop(ex[i], ey[i])) drops++;
      else exp_q.push_back(model_word(ex[i], ey[i], c));
      repeat (2) @(negedge clk);
      total++; if (drop_count !== 8'(sat255(drops)))
        begin bad++; $display("FAIL clip_drop%0d: got %0d want %0d", i, drop_count, sat255(drops)); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 298; i++) begin
      push(W, 0, 1, 10, ok);
      if (model_drop(W, 0)) drops++;
      else exp_q.push_back(model_word(W, 0, 1));
    end
    push(255, 255, 6, 10, ok);
    if (model_drop(255, 255)) drops++;
    else exp_q.push_back(model_word(255, 255, 6));
    wait_idle(50, ok);
    total++; if (drop_count !== 8'(sat255(drops)))
      begin bad++; $display("FAIL clip_saturate: got %0d want %0d", drop_count, sat255(drops)); end
    total++; if (obs_q.size() !== exp_q.size())
      begin bad++; $display("FAIL clip_writes: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL clip_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int drops = 0;
    int x, y, c;
    bit ok;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, W - 1);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, H - 1);
      c = $urandom_range(0, 7);
      in_valid = ($urandom_range(0, 2) != 0);
      in_x = 8'(x); in_y = 8'(y); in_color = 3'(c);
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (model_drop(x, y)) drops++;
        else exp_q.push_back(model_word(x, y, c));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_drain: busy still 1"); end
    total++; if (obs_q.size() !== exp_q.size())
      begin bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (drop_count !== 8'(sat255(drops)))
      begin bad++; $display("FAIL rand_drop: got %0d want %0d", drop_count, sat255(drops)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_clear_queued();
    test_reset_mid_clear();
    test_clip_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
